// File: rtl/player_motion_pkg.sv
// Shared definitions for the player motion block: game-state codes, facing
// encodings, sprite frames and playfield limits.
package player_motion_pkg;

    localparam logic [3:0] GS_TITLE  = 4'd0;
    localparam logic [3:0] GS_INTRO1 = 4'd1;
    localparam logic [3:0] GS_STAGE1 = 4'd2;
    localparam logic [3:0] GS_INTRO2 = 4'd3;
    localparam logic [3:0] GS_STAGE2 = 4'd4;
    localparam logic [3:0] GS_INTRO3 = 4'd5;
    localparam logic [3:0] GS_STAGE3 = 4'd6;
    localparam logic [3:0] GS_WIN    = 4'd7;
    localparam logic [3:0] GS_FAIL   = 4'd8;

    localparam int unsigned SPRITE_SIZE = 10;
    localparam logic [9:0]  X_MAX       = 10'd310;
    localparam logic [9:0]  Y_MAX       = 10'd230;
    localparam logic [3:0]  DEAD_FRAME  = 4'd8;
    localparam logic [3:0]  OFF_FRAME   = 4'd1;

    typedef enum logic [1:0] {
        FACE_UP    = 2'd0,
        FACE_DOWN  = 2'd1,
        FACE_LEFT  = 2'd2,
        FACE_RIGHT = 2'd3
    } facing_e;

    typedef enum logic [1:0] {
        MS_OFF,
        MS_IDLE,
        MS_WALK,
        MS_DEAD
    } motion_state_e;

    function automatic logic is_stage(input logic [3:0] gs);
        return (gs == GS_STAGE1) || (gs == GS_STAGE2) || (gs == GS_STAGE3);
    endfunction

endpackage

// File: rtl/player_motion_tick.sv
// Modulo-N counter with enable and synchronous clear; wrap_o pulses on the
// enabled cycle in which the count returns to zero.
module tick_divider #(
    parameter int unsigned MODULUS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic wrap_o
);

    localparam int unsigned W = (MODULUS > 1) ? $clog2(MODULUS) : 1;

    logic [W-1:0] cnt_q;

    assign wrap_o = en_i && !clr_i && (cnt_q == W'(MODULUS - 1));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= wrap_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/player_motion.sv
// Player sprite motion: stage-gated OFF/IDLE/WALK/DEAD FSM, divided movement
// ticks with saturating position, facing latch and walk-frame animation.
module player_motion
    import player_motion_pkg::*;
#(
    parameter int unsigned MOVE_DIV = 500000,
    parameter int unsigned ANIM_DIV = 4,
    parameter int unsigned STEP     = 1,
    parameter int unsigned START_X  = 10,
    parameter int unsigned START_Y  = 115
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       die,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [3:0] player_state,
    output logic       moving
);

    motion_state_e state_q, state_d;
    facing_e       facing_q, facing_d, dir;
    logic [8:0]    x_q, x_d, y_q, y_d;
    logic [3:0]    frame_q, frame_d;
    logic [3:0]    prev_gs_q;
    logic          phase_q, phase_d;
    logic          moving_q;
    logic          in_stage, stage_change, any_key;
    logic          move_tick, anim_wrap, do_move, walking;
    logic [9:0]    x_w, y_w, step_w;

    assign in_stage     = is_stage(state);
    assign stage_change = (state != prev_gs_q);
    assign any_key      = key_up | key_down | key_left | key_right;
    assign walking      = (state_q == MS_WALK);

    tick_divider #(.MODULUS(MOVE_DIV)) u_move_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (walking),
        .clr_i  (!walking),
        .wrap_o (move_tick)
    );

    tick_divider #(.MODULUS(ANIM_DIV)) u_anim_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (move_tick),
        .clr_i  (!walking),
        .wrap_o (anim_wrap)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            MS_OFF:  if (in_stage) state_d = MS_IDLE;
            MS_IDLE: if (die) state_d = MS_DEAD; else if (any_key) state_d = MS_WALK;
            MS_WALK: if (die) state_d = MS_DEAD; else if (!any_key) state_d = MS_IDLE;
            MS_DEAD: state_d = MS_DEAD;
        endcase
        // Leaving the stage, or hopping straight to another stage, respawns via OFF.
        if (!in_stage || (state_q != MS_OFF && stage_change)) state_d = MS_OFF;
    end

    always_comb begin
        dir = facing_q;
        if (key_up)         dir = FACE_UP;
        else if (key_down)  dir = FACE_DOWN;
        else if (key_left)  dir = FACE_LEFT;
        else if (key_right) dir = FACE_RIGHT;
    end

    assign do_move = move_tick && (state_d == MS_WALK);
    assign x_w     = {1'b0, x_q};
    assign y_w     = {1'b0, y_q};
    assign step_w  = 10'(STEP);

    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        facing_d = facing_q;
        phase_d  = phase_q;
        if (state_d == MS_OFF) begin
            x_d = 9'(START_X);
            y_d = 9'(START_Y);
        end else if (do_move) begin
            facing_d = dir;
            unique case (dir)
                FACE_UP:    y_d = (y_w < step_w)          ? 9'd0        : 9'(y_w - step_w);
                FACE_DOWN:  y_d = (y_w + step_w > Y_MAX)  ? 9'(Y_MAX)   : 9'(y_w + step_w);
                FACE_LEFT:  x_d = (x_w < step_w)          ? 9'd0        : 9'(x_w - step_w);
                FACE_RIGHT: x_d = (x_w + step_w > X_MAX)  ? 9'(X_MAX)   : 9'(x_w + step_w);
            endcase
        end
        if (state_d != MS_WALK) phase_d = 1'b0;
        else if (anim_wrap)     phase_d = ~phase_q;

        unique case (state_d)
            MS_OFF:  frame_d = OFF_FRAME;
            MS_DEAD: frame_d = DEAD_FRAME;
            default: frame_d = {1'b0, facing_d, phase_d};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= MS_OFF;
            facing_q  <= FACE_RIGHT;
            phase_q   <= 1'b0;
            x_q       <= 9'(START_X);
            y_q       <= 9'(START_Y);
            frame_q   <= OFF_FRAME;
            moving_q  <= 1'b0;
            prev_gs_q <= GS_TITLE;
        end else begin
            state_q   <= state_d;
            facing_q  <= facing_d;
            phase_q   <= phase_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            moving_q  <= (state_d == MS_WALK);
            prev_gs_q <= state;
        end
    end

    assign player_x     = x_q;
    assign player_y     = y_q;
    assign player_state = frame_q;
    assign moving       = moving_q;

endmodule
